// File: rtl/qd_pkg.sv
// Shared types and helpers for the quadrature decoder: resolution modes,
// FSM states and Gray-step classification.
package qd_pkg;

   localparam logic [1:0] QD_X1 = 2'd0;
   localparam logic [1:0] QD_X2 = 2'd1;
   localparam logic [1:0] QD_X4 = 2'd2;

   typedef enum logic {QD_INIT, QD_RUN} qd_state_e;

   typedef enum logic [1:0] {QD_NONE, QD_FWD, QD_REV, QD_ILL} qd_step_e;

   // Position along the forward cycle 00->10->11->01 ({A,B}), as a 2-bit ring index.
   function automatic logic [1:0] qd_pos(input logic [1:0] ab);
      return {ab[0], ab[1] ^ ab[0]};
   endfunction

   function automatic qd_step_e qd_classify(input logic [1:0] prev, input logic [1:0] pair);
      logic [1:0] d;
      qd_step_e   s;
      d = qd_pos(pair) - qd_pos(prev);
      case (d)
         2'd0:    s = QD_NONE;
         2'd1:    s = QD_FWD;
         2'd3:    s = QD_REV;
         default: s = QD_ILL;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Pin inputs, controls and counter-side strobes of the quadrature decoder.
interface quad_decoder_if #(
   parameter int ERR_W = 8
);
   logic             i_a;
   logic             i_b;
   logic             i_idx;
   logic             i_en;
   logic [1:0]       i_mode;
   logic             i_idx_en;
   logic             i_err_clr;
   logic             o_cnt_en;
   logic             o_dir;
   logic             o_clr;
   logic             o_err_flg;
   logic [ERR_W-1:0] o_err_cnt;

   modport slave (
      input  i_a, i_b, i_idx, i_en, i_mode, i_idx_en, i_err_clr,
      output o_cnt_en, o_dir, o_clr, o_err_flg, o_err_cnt
   );

   modport master (
      output i_a, i_b, i_idx, i_en, i_mode, i_idx_en, i_err_clr,
      input  o_cnt_en, o_dir, o_clr, o_err_flg, o_err_cnt
   );
endinterface

// File: rtl/qd_glitch_filter.sv
// Two-flop synchroniser followed by a hold-time filter: the output only
// follows the pin once it has held a new level for FILT_LEN clocks.
module qd_glitch_filter #(
   parameter int FILT_LEN = 4,
   parameter int FILT_W   = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level
);
   logic [1:0]        sync;
   logic [FILT_W-1:0] cnt;
   logic              filt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
         cnt  <= '0;
         filt <= 1'b0;
      end else begin
         sync <= {sync[0], pin};
         if (sync[1] == filt) begin
            cnt <= '0;
         end else if (cnt == FILT_W'(FILT_LEN - 1)) begin
            filt <= ~filt;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign level = filt;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature front end: filtered A/B/idx pins decoded into count, direction,
// clear and illegal-transition outputs for a 16-bit up/down counter.
module quad_decoder
   import qd_pkg::*;
#(
   parameter int FILT_LEN = 4,
   parameter int FILT_W   = 4,
   parameter int ERR_W    = 8
) (
   input  logic          i_sysclk,
   input  logic          i_sysrst,
   quad_decoder_if.slave bus
);
   // INIT spans FILT_LEN+3 clocks so the filters settle on the pins before prev is seeded.
   localparam logic [FILT_W:0] SETTLE_LAST = (FILT_W + 1)'(FILT_LEN + 2);

   logic [2:0]       pins, filt;
   logic [1:0]       pair, prev, prev_n;
   logic             idx_f, idx_q;
   qd_state_e        state, state_n;
   logic [FILT_W:0]  settle, settle_n;
   logic             cnt_en, cnt_en_n, dir, dir_n, clr, clr_n, err_flg, err_flg_n;
   logic [ERR_W-1:0] err_cnt, err_cnt_n, err_base;
   qd_step_e         step;
   logic             counted;

   assign pins = {bus.i_a, bus.i_b, bus.i_idx};

   qd_glitch_filter #(.FILT_LEN(FILT_LEN), .FILT_W(FILT_W)) u_filt [2:0] (
      .clk   (i_sysclk),
      .rst   (i_sysrst),
      .pin   (pins),
      .level (filt)
   );

   assign pair  = filt[2:1];
   assign idx_f = filt[0];
   assign step  = qd_classify(prev, pair);

   // x1 counts only the 00<->10 edge (B low on both sides); x2 counts every A edge.
   always_comb begin
      case (bus.i_mode)
         QD_X1:   counted = ~prev[0] & ~pair[0];
         QD_X2:   counted = prev[1] ^ pair[1];
         default: counted = 1'b1;
      endcase
   end

   always_ff @(posedge i_sysclk) begin
      if (i_sysrst) begin
         state   <= QD_INIT;
         settle  <= '0;
         prev    <= 2'b00;
         cnt_en  <= 1'b0;
         dir     <= 1'b1;
         clr     <= 1'b0;
         err_flg <= 1'b0;
         err_cnt <= '0;
         idx_q   <= 1'b0;
      end else begin
         state   <= state_n;
         settle  <= settle_n;
         prev    <= prev_n;
         cnt_en  <= cnt_en_n;
         dir     <= dir_n;
         clr     <= clr_n;
         err_flg <= err_flg_n;
         err_cnt <= err_cnt_n;
         idx_q   <= idx_f;
      end
   end

   always_comb begin
      state_n   = state;
      settle_n  = settle;
      prev_n    = prev;
      cnt_en_n  = 1'b0;
      dir_n     = dir;
      clr_n     = 1'b0;
      err_flg_n = bus.i_err_clr ? 1'b0 : err_flg;
      err_base  = bus.i_err_clr ? '0 : err_cnt;
      err_cnt_n = err_base;
      case (state)
         QD_INIT: begin
            if (settle == SETTLE_LAST) begin
               state_n = QD_RUN;
               prev_n  = pair;
            end else begin
               settle_n = settle + 1'b1;
            end
         end
         QD_RUN: begin
            prev_n = pair;
            // A new illegal step outranks a simultaneous clear, leaving a count of 1.
            if (step == QD_ILL) begin
               err_flg_n = 1'b1;
               err_cnt_n = (&err_base) ? err_base : err_base + 1'b1;
            end
            if (bus.i_en && (step == QD_FWD || step == QD_REV) && counted) begin
               cnt_en_n = 1'b1;
               dir_n    = (step == QD_FWD);
            end
            if (bus.i_en && bus.i_idx_en && idx_f && !idx_q && pair == 2'b00)
               clr_n = 1'b1;
         end
         default: state_n = QD_INIT;
      endcase
   end

   assign bus.o_cnt_en  = cnt_en;
   assign bus.o_dir     = dir;
   assign bus.o_clr     = clr;
   assign bus.o_err_flg = err_flg;
   assign bus.o_err_cnt = err_cnt;

endmodule

// File: tb/tb_quad_decoder.sv
// Randomised bench for quad_decoder against a step-table reference model
// that timestamps every expected count strobe.
module tb_quad_decoder;
   localparam int FILT_LEN = 4;
   localparam int ERR_W    = 8;
   localparam int LAT      = FILT_LEN + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   quad_decoder_if #(.ERR_W(ERR_W)) bus ();

   quad_decoder #(.FILT_LEN(FILT_LEN), .FILT_W(4), .ERR_W(ERR_W)) dut (
      .i_sysclk (clk),
      .i_sysrst (rst),
      .bus      (bus)
   );

   int   cyc = 0;
   int   pulse_cyc[$];
   logic pulse_dir[$];
   int   n_clr = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.o_cnt_en === 1'b1) begin
         pulse_cyc.push_back(cyc);
         pulse_dir.push_back(bus.o_dir);
      end
      if (bus.o_clr === 1'b1) n_clr <= n_clr + 1;
   end

   int         n_vec = 0, n_fail = 0;
   logic [1:0] cur;
   int         exp_cyc[$];
   logic       exp_dir[$];
   int         exp_err;
   logic       exp_flg;

   function automatic int pos_of(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] step_of(input logic [1:0] ab, input bit fwd);
      case (ab)
         2'b00:   return fwd ? 2'b10 : 2'b01;
         2'b10:   return fwd ? 2'b11 : 2'b00;
         2'b11:   return fwd ? 2'b01 : 2'b10;
         default: return fwd ? 2'b00 : 2'b11;
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive a new pair and update the model: a strobe is due LAT cycles after the sampling edge.
   task automatic drive(input logic [1:0] np, input int hold);
      int po, pn, k;
      bit fwd, legal, counted;
      po    = pos_of(cur);
      pn    = pos_of(np);
      fwd   = (pn == (po + 1) % 4);
      legal = fwd || (po == (pn + 1) % 4);
      bus.i_a = np[1];
      bus.i_b = np[0];
      k = cyc + 1;
      if (np != cur) begin
         if (legal) begin
            case (bus.i_mode)
               2'd0:    counted = (cur == 2'b00 && np == 2'b10) || (cur == 2'b10 && np == 2'b00);
               2'd1:    counted = (cur[1] != np[1]);
               default: counted = 1'b1;
            endcase
            if (counted && bus.i_en) begin
               exp_cyc.push_back(k + LAT);
               exp_dir.push_back(fwd);
            end
         end else begin
            exp_flg = 1'b1;
            if (exp_err < (1 << ERR_W) - 1) exp_err++;
         end
      end
      cur = np;
      tick(hold);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(3);
      n_vec += 5;
      if (bus.o_cnt_en !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_en: got %b want 0", bus.o_cnt_en); end
      if (bus.o_dir !== 1'b1) begin n_fail++; $display("FAIL reset_dir: got %b want 1", bus.o_dir); end
      if (bus.o_clr !== 1'b0) begin n_fail++; $display("FAIL reset_clr: got %b want 0", bus.o_clr); end
      if (bus.o_err_flg !== 1'b0) begin n_fail++; $display("FAIL reset_err_flg: got %b want 0", bus.o_err_flg); end
      if (bus.o_err_cnt !== '0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", bus.o_err_cnt); end
      rst = 1'b0;
      tick(12);
   endtask

   task automatic test_x4_forward;
      int p0, ups;
      bus.i_mode = 2'd2;
      exp_cyc.delete(); exp_dir.delete();
      p0 = pulse_cyc.size();
      for (int i = 0; i < 40; i++) drive(step_of(cur, 1'b1), 8);
      tick(LAT + 2);
      ups = 0;
      for (int i = p0; i < pulse_cyc.size(); i++) if (pulse_dir[i] === 1'b1) ups++;
      n_vec += 4;
      if (pulse_cyc.size() - p0 != 40) begin n_fail++; $display("FAIL x4_count: got %0d want 40", pulse_cyc.size() - p0); end
      if (ups != 40) begin n_fail++; $display("FAIL x4_dir_up: got %0d want 40", ups); end
      if (pulse_cyc.size() > p0 && exp_cyc.size() > 0) begin
         if (pulse_cyc[p0] != exp_cyc[0]) begin n_fail++; $display("FAIL x4_latency: got cycle %0d want %0d", pulse_cyc[p0], exp_cyc[0]); end
      end else begin
         n_fail++; $display("FAIL x4_latency: got no pulse want cycle k+%0d", LAT);
      end
      if (bus.o_err_flg !== 1'b0) begin n_fail++; $display("FAIL x4_no_err: got %b want 0", bus.o_err_flg); end
   endtask

   task automatic test_x1_x2_reverse;
      int p0;
      for (int m = 0; m < 2; m++) begin
         bus.i_mode = 2'(m);
         exp_cyc.delete(); exp_dir.delete();
         p0 = pulse_cyc.size();
         for (int i = 0; i < 12; i++) drive(step_of(cur, 1'b0), 8);
         tick(LAT + 2);
         n_vec++;
         if (pulse_cyc.size() - p0 != (m == 0 ? 3 : 6) || exp_cyc.size() != (m == 0 ? 3 : 6)) begin
            n_fail++;
            $display("FAIL rev_mode%0d_count: got %0d model %0d want %0d", m, pulse_cyc.size() - p0, exp_cyc.size(), m == 0 ? 3 : 6);
         end
         for (int i = 0; i < exp_cyc.size() && p0 + i < pulse_cyc.size(); i++) begin
            n_vec++;
            if (pulse_cyc[p0 + i] != exp_cyc[i] || pulse_dir[p0 + i] !== 1'b0) begin
               n_fail++;
               $display("FAIL rev_mode%0d_pulse%0d: got cyc %0d dir %b want cyc %0d dir 0", m, i, pulse_cyc[p0 + i], pulse_dir[p0 + i], exp_cyc[i]);
            end
         end
      end
   endtask

   task automatic test_random_walk;
      int p0;
      for (int r = 0; r < 6; r++) begin
         bus.i_mode = 2'($urandom_range(0, 3));
         exp_cyc.delete(); exp_dir.delete();
         p0 = pulse_cyc.size();
         for (int i = 0; i < 30; i++) drive(step_of(cur, 1'($urandom_range(0, 1))), $urandom_range(5, 10));
         tick(LAT + 2);
         n_vec++;
         if (pulse_cyc.size() - p0 != exp_cyc.size()) begin
            n_fail++;
            $display("FAIL walk%0d_count: mode %0d got %0d want %0d", r, bus.i_mode, pulse_cyc.size() - p0, exp_cyc.size());
         end
         for (int i = 0; i < exp_cyc.size() && p0 + i < pulse_cyc.size(); i++) begin
            n_vec++;
            if (pulse_cyc[p0 + i] != exp_cyc[i] || pulse_dir[p0 + i] !== exp_dir[i]) begin
               n_fail++;
               $display("FAIL walk%0d_pulse%0d: got cyc %0d dir %b want cyc %0d dir %b", r, i, pulse_cyc[p0 + i], pulse_dir[p0 + i], exp_cyc[i], exp_dir[i]);
            end
         end
      end
      bus.i_mode = 2'd2;
      while (cur != 2'b00) drive(step_of(cur, 1'b0), 8);
      tick(LAT);
   endtask

   task automatic test_illegal;
      int p0;
      bus.i_err_clr = 1'b1; tick(1); bus.i_err_clr = 1'b0;
      exp_err = 0; exp_flg = 1'b0;
      p0 = pulse_cyc.size();
      drive(2'b11, 8);
      tick(LAT);
      n_vec += 3;
      if (pulse_cyc.size() != p0) begin n_fail++; $display("FAIL illegal_no_strobe: got %0d want 0", pulse_cyc.size() - p0); end
      if (bus.o_err_flg !== exp_flg) begin n_fail++; $display("FAIL illegal_flg: got %b want %b", bus.o_err_flg, exp_flg); end
      if (bus.o_err_cnt !== ERR_W'(exp_err)) begin n_fail++; $display("FAIL illegal_cnt1: got %0d want %0d", bus.o_err_cnt, exp_err); end
      drive(2'b00, 8);
      tick(LAT);
      n_vec++;
      if (bus.o_err_cnt !== ERR_W'(exp_err)) begin n_fail++; $display("FAIL illegal_cnt2: got %0d want %0d", bus.o_err_cnt, exp_err); end
      // Clear lands on exactly the edge that records the new illegal step.
      drive(2'b11, LAT);
      bus.i_err_clr = 1'b1; tick(1); bus.i_err_clr = 1'b0;
      exp_err = 1; exp_flg = 1'b1;
      tick(2);
      n_vec += 2;
      if (bus.o_err_flg !== exp_flg) begin n_fail++; $display("FAIL clr_coincide_flg: got %b want 1", bus.o_err_flg); end
      if (bus.o_err_cnt !== ERR_W'(exp_err)) begin n_fail++; $display("FAIL clr_coincide_cnt: got %0d want 1", bus.o_err_cnt); end
      bus.i_err_clr = 1'b1; tick(1); bus.i_err_clr = 1'b0;
      exp_err = 0; exp_flg = 1'b0;
      tick(1);
      n_vec += 2;
      if (bus.o_err_flg !== 1'b0) begin n_fail++; $display("FAIL clr_alone_flg: got %b want 0", bus.o_err_flg); end
      if (bus.o_err_cnt !== '0) begin n_fail++; $display("FAIL clr_alone_cnt: got %0d want 0", bus.o_err_cnt); end
      drive(2'b01, 8);
      drive(2'b00, 8);
      tick(LAT);
   endtask

   task automatic test_glitch_saturate;
      int p0;
      p0 = pulse_cyc.size();
      bus.i_a = 1'b1; tick(3); bus.i_a = 1'b0;
      tick(12);
      n_vec += 2;
      if (pulse_cyc.size() != p0) begin n_fail++; $display("FAIL glitch_no_strobe: got %0d want 0", pulse_cyc.size() - p0); end
      if (bus.o_err_flg !== 1'b0) begin n_fail++; $display("FAIL glitch_no_err: got %b want 0", bus.o_err_flg); end
      exp_cyc.delete(); exp_dir.delete();
      drive(2'b10, 8);
      tick(LAT);
      n_vec++;
      if (pulse_cyc.size() - p0 != 1 || exp_cyc.size() != 1 || pulse_dir[pulse_cyc.size() - 1] !== 1'b1) begin
         n_fail++; $display("FAIL glitch_then_step: got %0d pulses want 1 up", pulse_cyc.size() - p0);
      end
      drive(2'b00, 8);
      for (int i = 0; i < 258; i++) drive(cur == 2'b00 ? 2'b11 : 2'b00, 5);
      tick(LAT + 2);
      n_vec += 2;
      if (bus.o_err_cnt !== ERR_W'(exp_err) || exp_err != 255) begin n_fail++; $display("FAIL err_saturate: got %0d want %0d", bus.o_err_cnt, exp_err); end
      if (bus.o_err_flg !== 1'b1) begin n_fail++; $display("FAIL err_sat_flg: got %b want 1", bus.o_err_flg); end
      bus.i_err_clr = 1'b1; tick(1); bus.i_err_clr = 1'b0;
      exp_err = 0; exp_flg = 1'b0;
      tick(2);
   endtask

   task automatic test_index_enable;
      int c0, p0;
      c0 = n_clr;
      bus.i_idx = 1'b1; tick(12); bus.i_idx = 1'b0; tick(12);
      n_vec++;
      if (n_clr - c0 != 1) begin n_fail++; $display("FAIL idx_pair00: got %0d want 1", n_clr - c0); end
      drive(2'b10, 8); drive(2'b11, 8); tick(LAT);
      c0 = n_clr;
      bus.i_idx = 1'b1; tick(12); bus.i_idx = 1'b0; tick(12);
      n_vec++;
      if (n_clr - c0 != 0) begin n_fail++; $display("FAIL idx_pair11: got %0d want 0", n_clr - c0); end
      drive(2'b10, 8); drive(2'b00, 8); tick(LAT);
      bus.i_idx_en = 1'b0;
      c0 = n_clr;
      bus.i_idx = 1'b1; tick(12); bus.i_idx = 1'b0; tick(12);
      bus.i_idx_en = 1'b1;
      n_vec++;
      if (n_clr - c0 != 0) begin n_fail++; $display("FAIL idx_disabled: got %0d want 0", n_clr - c0); end
      exp_cyc.delete(); exp_dir.delete();
      p0 = pulse_cyc.size();
      bus.i_en = 1'b0;
      for (int i = 0; i < 5; i++) drive(step_of(cur, 1'b1), 8);
      tick(12);
      bus.i_en = 1'b1;
      tick(12);
      n_vec++;
      if (pulse_cyc.size() != p0) begin n_fail++; $display("FAIL en_off_strobes: got %0d want 0", pulse_cyc.size() - p0); end
      drive(step_of(cur, 1'b1), 8);
      tick(LAT);
      n_vec++;
      if (pulse_cyc.size() - p0 != 1 || exp_cyc.size() != 1 || pulse_cyc[pulse_cyc.size() - 1] != exp_cyc[0]) begin
         n_fail++; $display("FAIL en_resume: got %0d pulses want 1 at cycle %0d", pulse_cyc.size() - p0, exp_cyc.size() > 0 ? exp_cyc[0] : -1);
      end
   endtask

   task automatic test_reset_mid;
      int p0;
      while (cur != 2'b00) drive(step_of(cur, 1'b0), 8);
      drive(2'b11, 8);
      tick(LAT);
      n_vec += 2;
      if (bus.o_dir !== 1'b0) begin n_fail++; $display("FAIL pre_reset_dir: got %b want 0", bus.o_dir); end
      if (bus.o_err_flg !== 1'b1) begin n_fail++; $display("FAIL pre_reset_flg: got %b want 1", bus.o_err_flg); end
      rst = 1'b1;
      tick(2);
      exp_err = 0; exp_flg = 1'b0;
      n_vec += 4;
      if (bus.o_dir !== 1'b1) begin n_fail++; $display("FAIL mid_reset_dir: got %b want 1", bus.o_dir); end
      if (bus.o_cnt_en !== 1'b0) begin n_fail++; $display("FAIL mid_reset_cnt_en: got %b want 0", bus.o_cnt_en); end
      if (bus.o_err_flg !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flg: got %b want 0", bus.o_err_flg); end
      if (bus.o_err_cnt !== '0) begin n_fail++; $display("FAIL mid_reset_cnt: got %0d want 0", bus.o_err_cnt); end
      p0 = pulse_cyc.size();
      rst = 1'b0;
      tick(20);
      n_vec += 2;
      if (pulse_cyc.size() != p0) begin n_fail++; $display("FAIL release_no_strobe: got %0d want 0", pulse_cyc.size() - p0); end
      if (bus.o_err_flg !== 1'b0) begin n_fail++; $display("FAIL release_no_err: got %b want 0", bus.o_err_flg); end
      exp_cyc.delete(); exp_dir.delete();
      drive(2'b01, 8);
      tick(LAT);
      n_vec++;
      if (pulse_cyc.size() - p0 != 1 || exp_cyc.size() != 1 || pulse_dir[pulse_cyc.size() - 1] !== 1'b1 ||
          pulse_cyc[pulse_cyc.size() - 1] != exp_cyc[0]) begin
         n_fail++; $display("FAIL post_reset_step: got %0d pulses want 1 up at cycle %0d", pulse_cyc.size() - p0, exp_cyc.size() > 0 ? exp_cyc[0] : -1);
      end
   endtask

   initial begin
      bus.i_a = 1'b0; bus.i_b = 1'b0; bus.i_idx = 1'b0;
      bus.i_en = 1'b1; bus.i_mode = 2'd2; bus.i_idx_en = 1'b1; bus.i_err_clr = 1'b0;
      cur = 2'b00; exp_err = 0; exp_flg = 1'b0;
      test_reset;
      test_x4_forward;
      test_x1_x2_reverse;
      test_random_walk;
      test_illegal;
      test_glitch_saturate;
      test_index_enable;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
